// File: rtl/stack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stack_pkg                                                 |
// | Purpose  : Shared command and state encodings for the stack_ext LIFO |
// |            and its bus interface.                                    |
// | Contents : t_stack_cmd   - 2-bit command (nop/push/pop/replace)      |
// |            t_stack_state - controller state                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package stack_pkg;

   typedef enum logic [1:0] {
      CmdNop     = 2'b00,
      CmdPush    = 2'b01,
      CmdPop     = 2'b10,
      CmdReplace = 2'b11
   } t_stack_cmd;

   typedef enum logic [1:0] {
      WaitCommand = 2'b00,
      Push        = 2'b01,
      Pop         = 2'b10,
      Replace     = 2'b11
   } t_stack_state;

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_ext_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stack_ext_if                                              |
// | Purpose  : Command/status bundle between a controller and stack_ext. |
// | Signals  : in_cmd, in_data            controller -> stack            |
// |            out_top, out_count, out_empty, out_full, out_ready,       |
// |            out_err                    stack -> controller            |
// | Modports : master (controller side), slave (stack side)              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface stack_ext_if
   import stack_pkg::*;
#(
   parameter int ADDR_BITS = 3,
   parameter int WORD_BITS = 8
);

   t_stack_cmd             in_cmd;
   logic [WORD_BITS-1:0]   in_data;
   logic [WORD_BITS-1:0]   out_top;
   logic [ADDR_BITS:0]     out_count;
   logic                   out_empty;
   logic                   out_full;
   logic                   out_ready;
   logic                   out_err;

   modport master (
      output in_cmd, in_data,
      input  out_top, out_count, out_empty, out_full, out_ready, out_err
   );

   modport slave (
      input  in_cmd, in_data,
      output out_top, out_count, out_empty, out_full, out_ready, out_err
   );

endinterface : stack_ext_if
`default_nettype wire

// File: rtl/stack_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stack_ram                                                 |
// | Purpose  : Storage array for stack_ext. One synchronous write port,  |
// |            one asynchronous read port. Contents are not reset.       |
// | Ports    : in_clk   - clock, rising edge                             |
// |            in_we    - write enable                                   |
// |            in_waddr - write address                                  |
// |            in_wdata - write data                                     |
// |            in_raddr - read address                                   |
// |            out_rdata- read data (combinational)                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module stack_ram #(
   parameter int ADDR_BITS = 3,
   parameter int WORD_BITS = 8
) (
   input  wire logic                 in_clk,
   input  wire logic                 in_we,
   input  wire logic [ADDR_BITS-1:0] in_waddr,
   input  wire logic [WORD_BITS-1:0] in_wdata,
   input  wire logic [ADDR_BITS-1:0] in_raddr,
   output logic      [WORD_BITS-1:0] out_rdata
);

   localparam int C_NUM_WORDS = 2 ** ADDR_BITS;

   logic [WORD_BITS-1:0] mem_q [C_NUM_WORDS];

   always_ff @(posedge in_clk) begin
      if (in_we) begin
         mem_q[in_waddr] <= in_wdata;
      end
   end

   assign out_rdata = mem_q[in_raddr];

endmodule : stack_ram
`default_nettype wire

// File: rtl/stack_ext.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stack_ext                                                 |
// | Purpose  : LIFO stack with push / pop / replace-top, occupancy count,|
// |            full/empty flags and rejection of over/underflowing       |
// |            commands. One command accepted per two clock cycles.      |
// | Ports    : in_clk   - clock, rising edge                             |
// |            in_rst_n - asynchronous active-low reset                  |
// |            bus      - stack_ext_if.slave (command in, status out)    |
// | Options  : STACK_ERR_EN - when defined, a rejected command sets the  |
// |            sticky out_err flag; otherwise out_err is tied to 0.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module stack_ext
   import stack_pkg::*;
#(
   parameter int ADDR_BITS = 3,
   parameter int WORD_BITS = 8
) (
   input  wire logic    in_clk,
   input  wire logic    in_rst_n,
   stack_ext_if.slave   bus
);

   localparam int                 C_NUM_WORDS  = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] C_FULL_COUNT = (ADDR_BITS + 1)'(C_NUM_WORDS);

   t_stack_state          state_q, state_d;
   logic [ADDR_BITS-1:0]  sp_q,    sp_d;
   logic [ADDR_BITS:0]    count_q, count_d;
   logic [WORD_BITS-1:0]  data_q,  data_d;
   logic                  ready_q, ready_d;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_we;
   logic [ADDR_BITS-1:0]  w_waddr;
   logic [WORD_BITS-1:0]  w_rdata;

   assign w_empty = (count_q == '0);
   assign w_full  = (count_q == C_FULL_COUNT);

   stack_ram #(
      .ADDR_BITS (ADDR_BITS),
      .WORD_BITS (WORD_BITS)
   ) u_ram (
      .in_clk    (in_clk),
      .in_we     (w_we),
      .in_waddr  (w_waddr),
      .in_wdata  (data_q),
      .in_raddr  (sp_q),
      .out_rdata (w_rdata)
   );

   always_comb begin
      state_d = state_q;
      sp_d    = sp_q;
      count_d = count_q;
      data_d  = data_q;
      w_we    = 1'b0;
      w_waddr = sp_q;
      unique case (state_q)
         WaitCommand: begin
            // Rejected commands simply fall through and stay here.
            case (bus.in_cmd)
               CmdPush: if (!w_full) begin
                  state_d = Push;
                  data_d  = bus.in_data;
               end
               CmdPop: if (!w_empty) begin
                  state_d = Pop;
               end
               CmdReplace: if (!w_empty) begin
                  state_d = Replace;
                  data_d  = bus.in_data;
               end
               default: ;
            endcase
         end
         Push: begin
            // Stack grows downward; sp wraps so the first push lands at the top address.
            w_we    = 1'b1;
            w_waddr = sp_q - 1'b1;
            sp_d    = sp_q - 1'b1;
            count_d = count_q + 1'b1;
            state_d = WaitCommand;
         end
         Pop: begin
            sp_d    = sp_q + 1'b1;
            count_d = count_q - 1'b1;
            state_d = WaitCommand;
         end
         Replace: begin
            w_we    = 1'b1;
            state_d = WaitCommand;
         end
         default: state_d = WaitCommand;
      endcase
      ready_d = (state_d == WaitCommand);
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q <= WaitCommand;
         sp_q    <= '0;
         count_q <= '0;
         data_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
         count_q <= count_d;
         data_q  <= data_d;
         ready_q <= ready_d;
      end
   end

`ifdef STACK_ERR_EN
   logic w_illegal;
   logic err_q, err_d;

   assign w_illegal = (state_q == WaitCommand) &&
                      (((bus.in_cmd == CmdPush) && w_full) ||
                       (((bus.in_cmd == CmdPop) || (bus.in_cmd == CmdReplace)) && w_empty));

   always_comb begin
      err_d = err_q | w_illegal;
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.out_err = err_q;
`else
   assign bus.out_err = 1'b0;
`endif

   // Memory is not reset, so mask the read while nothing is stored.
   assign bus.out_top   = w_empty ? '0 : w_rdata;
   assign bus.out_count = count_q;
   assign bus.out_empty = w_empty;
   assign bus.out_full  = w_full;
   assign bus.out_ready = ready_q;

endmodule : stack_ext
`default_nettype wire

// File: tb/tb_stack_ext.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_stack_ext                                              |
// | Purpose  : Self-checking bench for stack_ext (ADDR_BITS=3, 8-bit).   |
// |            A reference LIFO predicts the status after each command;  |
// |            predictions and observations are queued and compared.     |
// | Options  : STACK_ERR_EN - selects the expected out_err behaviour.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_stack_ext;
   import stack_pkg::*;

   localparam int ADDR_BITS = 3;
   localparam int WORD_BITS = 8;
   localparam int DEPTH     = 2 ** ADDR_BITS;
`ifdef STACK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [WORD_BITS-1:0] top;
      logic [ADDR_BITS:0]   count;
      logic                 empty;
      logic                 full;
      logic                 mid_ready;   // out_ready in the cycle after the sampling edge
      logic                 ready;
      logic                 err;
   } res_t;

   logic in_clk;
   logic in_rst_n;

   stack_ext_if #(.ADDR_BITS(ADDR_BITS), .WORD_BITS(WORD_BITS)) bus ();

   stack_ext #(.ADDR_BITS(ADDR_BITS), .WORD_BITS(WORD_BITS)) dut (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .bus      (bus.slave)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   int   total = 0;
   int   bad   = 0;
   res_t exp_q[$];
   res_t obs_q[$];
   logic [WORD_BITS-1:0] m_stack[$];
   logic m_err = 1'b0;

   function automatic res_t model_status(input logic mid_ready);
      res_t r;
      r.top       = (m_stack.size() != 0) ? m_stack[m_stack.size()-1] : '0;
      r.count     = (ADDR_BITS+1)'(m_stack.size());
      r.empty     = (m_stack.size() == 0);
      r.full      = (m_stack.size() == DEPTH);
      r.mid_ready = mid_ready;
      r.ready     = 1'b1;
      r.err       = m_err;
      return r;
   endfunction

   function automatic res_t dut_status(input logic mid_ready);
      res_t r;
      r.top       = bus.out_top;
      r.count     = bus.out_count;
      r.empty     = bus.out_empty;
      r.full      = bus.out_full;
      r.mid_ready = mid_ready;
      r.ready     = bus.out_ready;
      r.err       = bus.out_err;
      return r;
   endfunction

   // Issue one command (entered and left at 1 time unit after a rising edge),
   // queue the model's prediction and the DUT's observed status.
   task automatic do_cmd(input t_stack_cmd cmd, input logic [WORD_BITS-1:0] data);
      int   n = 0;
      logic legal;
      logic mid;
      while (bus.out_ready !== 1'b1 && n < 10) begin
         @(posedge in_clk); #1;
         n++;
      end
      if (n >= 10) begin
         total++; bad++;
         $display("FAIL ready_timeout: out_ready=%b after %0d cycles, need 1", bus.out_ready, n);
      end
      case (cmd)
         CmdPush:            legal = (m_stack.size() < DEPTH);
         CmdPop, CmdReplace: legal = (m_stack.size() != 0);
         default:            legal = 1'b0;
      endcase
      if (legal) begin
         case (cmd)
            CmdPush:    m_stack.push_back(data);
            CmdPop:     void'(m_stack.pop_back());
            CmdReplace: m_stack[m_stack.size()-1] = data;
            default: ;
         endcase
      end else if (cmd != CmdNop) begin
         m_err = m_err | ERR_EN;
      end
      exp_q.push_back(model_status(!legal));

      bus.in_cmd  = cmd;
      bus.in_data = data;
      @(posedge in_clk); #1;
      bus.in_cmd  = CmdNop;
      bus.in_data = WORD_BITS'($urandom);   // must not affect the executing command
      mid = bus.out_ready;
      if (legal) begin
         @(posedge in_clk); #1;
      end
      obs_q.push_back(dut_status(mid));
   endtask

   task automatic test_reset;
      res_t e;
      res_t o;
      e = '{top: '0, count: '0, empty: 1'b1, full: 1'b0, mid_ready: 1'b1, ready: 1'b1, err: 1'b0};
      in_rst_n    = 1'b0;
      bus.in_cmd  = CmdPush;      // ignored while in reset
      bus.in_data = 8'h99;
      #12;
      o = dut_status(bus.out_ready);
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL reset_held: got top=%h cnt=%0d flags=%b need top=%h cnt=%0d flags=%b",
                  o.top, o.count, {o.empty, o.full, o.ready, o.err}, e.top, e.count, {e.empty, e.full, e.ready, e.err});
      end
      bus.in_cmd = CmdNop;
      in_rst_n   = 1'b1;
      @(posedge in_clk); #1;
      o = dut_status(bus.out_ready);
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL reset_released: got top=%h cnt=%0d flags=%b need top=%h cnt=%0d flags=%b",
                  o.top, o.count, {o.empty, o.full, o.ready, o.err}, e.top, e.count, {e.empty, e.full, e.ready, e.err});
      end
   endtask

   task automatic test_push_pop;
      res_t e;
      res_t o;
      int   k = 0;
      do_cmd(CmdPush, 8'h11);
      do_cmd(CmdPush, 8'h22);
      do_cmd(CmdPush, 8'h33);
      do_cmd(CmdPop,  8'h00);
      do_cmd(CmdPop,  8'h00);
      do_cmd(CmdPop,  8'h00);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL push_pop[%0d]: got top=%h cnt=%0d e/f/rm/r/err=%b need top=%h cnt=%0d e/f/rm/r/err=%b",
                     k, o.top, o.count, {o.empty, o.full, o.mid_ready, o.ready, o.err},
                     e.top, e.count, {e.empty, e.full, e.mid_ready, e.ready, e.err});
         end
         k++;
      end
   endtask

   task automatic test_full;
      res_t e;
      res_t o;
      int   k = 0;
      for (int i = 1; i <= DEPTH; i++) do_cmd(CmdPush, 8'(i));
      do_cmd(CmdPush, 8'hFF);             // overflow, rejected
      do_cmd(CmdReplace, 8'hC3);          // back-to-back right after the rejection
      for (int i = 0; i < DEPTH; i++) do_cmd(CmdPop, 8'h00);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL full[%0d]: got top=%h cnt=%0d e/f/rm/r/err=%b need top=%h cnt=%0d e/f/rm/r/err=%b",
                     k, o.top, o.count, {o.empty, o.full, o.mid_ready, o.ready, o.err},
                     e.top, e.count, {e.empty, e.full, e.mid_ready, e.ready, e.err});
         end
         k++;
      end
   endtask

   task automatic test_empty_illegal;
      res_t e;
      res_t o;
      int   k = 0;
      do_cmd(CmdPop,     8'h00);
      do_cmd(CmdReplace, 8'hAA);
      do_cmd(CmdPush,    8'h5A);
      do_cmd(CmdPop,     8'h00);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL empty_illegal[%0d]: got top=%h cnt=%0d e/f/rm/r/err=%b need top=%h cnt=%0d e/f/rm/r/err=%b",
                     k, o.top, o.count, {o.empty, o.full, o.mid_ready, o.ready, o.err},
                     e.top, e.count, {e.empty, e.full, e.mid_ready, e.ready, e.err});
         end
         k++;
      end
   endtask

   task automatic test_replace;
      res_t e;
      res_t o;
      int   k = 0;
      do_cmd(CmdPush,    8'h10);
      do_cmd(CmdReplace, 8'h20);
      do_cmd(CmdPush,    8'h30);
      do_cmd(CmdReplace, 8'h40);
      do_cmd(CmdPop,     8'h00);
      do_cmd(CmdPop,     8'h00);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL replace[%0d]: got top=%h cnt=%0d e/f/rm/r/err=%b need top=%h cnt=%0d e/f/rm/r/err=%b",
                     k, o.top, o.count, {o.empty, o.full, o.mid_ready, o.ready, o.err},
                     e.top, e.count, {e.empty, e.full, e.mid_ready, e.ready, e.err});
         end
         k++;
      end
   endtask

   task automatic test_reset_mid_cmd;
      res_t e;
      res_t o;
      int   k = 0;
      do_cmd(CmdPush, 8'h61);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL rst_mid_pre[%0d]: got top=%h cnt=%0d need top=%h cnt=%0d", k, o.top, o.count, e.top, e.count);
         end
         k++;
      end
      // Start a push, then pull reset during the Push cycle, away from any edge.
      bus.in_cmd  = CmdPush;
      bus.in_data = 8'h77;
      @(posedge in_clk); #1;
      bus.in_cmd = CmdNop;
      total++;
      if (bus.out_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_busy: out_ready=%b need 0", bus.out_ready);
      end
      in_rst_n = 1'b0;
      m_stack.delete();
      m_err = 1'b0;
      e = model_status(1'b1);
      #1;
      o = dut_status(bus.out_ready);
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL rst_mid_async: got top=%h cnt=%0d e/f/r/err=%b need top=%h cnt=%0d e/f/r/err=%b",
                  o.top, o.count, {o.empty, o.full, o.ready, o.err}, e.top, e.count, {e.empty, e.full, e.ready, e.err});
      end
      #2;
      in_rst_n = 1'b1;
      @(posedge in_clk); #1;
      o = dut_status(bus.out_ready);
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL rst_mid_after: got top=%h cnt=%0d e/f/r/err=%b need top=%h cnt=%0d e/f/r/err=%b",
                  o.top, o.count, {o.empty, o.full, o.ready, o.err}, e.top, e.count, {e.empty, e.full, e.ready, e.err});
      end
      do_cmd(CmdPush, 8'h42);
      do_cmd(CmdPop,  8'h00);
      k = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL rst_mid_post[%0d]: got top=%h cnt=%0d e/f/rm/r/err=%b need top=%h cnt=%0d e/f/rm/r/err=%b",
                     k, o.top, o.count, {o.empty, o.full, o.mid_ready, o.ready, o.err},
                     e.top, e.count, {e.empty, e.full, e.mid_ready, e.ready, e.err});
         end
         k++;
      end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_full();
      test_empty_illegal();
      test_replace();
      test_reset_mid_cmd();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_stack_ext
`default_nettype wire
